// File: rtl/reset_sequencer.sv
// Power-up reset sequencer for NUM_CH clock sources: pulses pll_rst, waits for lock, then staggers domain resets.
// Optional macro RSTSEQ_LOCK_FILTER_EN: lock loss in RELEASE/RUN needs 4 consecutive synchronised-low cycles.
module reset_sequencer #(
  parameter int NUM_CH         = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MAX_RETRY      = 3
) (
  input  logic              clk_50M,
  input  logic              rst,
  input  logic [NUM_CH-1:0] lock_in,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              restart,
  output logic [NUM_CH-1:0] pll_rst,
  output logic [NUM_CH-1:0] rst_out_n,
  output logic              all_ready,
  output logic              fault,
  output logic [3:0]        retry_cnt
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ASSERT_PLL,
    WAIT_LOCK,
    RELEASE,
    RUN,
    FAULT
  } state_t;

  state_t            state, state_d;
  logic [NUM_CH-1:0] lock_meta, lock_sync;
  logic [NUM_CH-1:0] en_q, en_d;
  logic [HW-1:0]     hold_cnt, hold_d, hold_inc;
  logic [TW-1:0]     tmo_cnt, tmo_d, tmo_inc;
  logic [3:0]        retry_d;
  logic [NUM_CH-1:0] rel_d, pending, first;
  logic [NUM_CH-1:0] pll_d, rst_out_d;
  logic              locked, lost;

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      lock_meta <= '0;
      lock_sync <= '0;
    end else begin
      lock_meta <= lock_in;
      lock_sync <= lock_meta;
    end
  end

  assign locked = &(lock_sync | ~en_q);

`ifdef RSTSEQ_LOCK_FILTER_EN
  // Per channel count of preceding consecutive low cycles, saturating at 3; loss on the 4th low cycle.
  logic [1:0]        low_cnt [NUM_CH];
  logic [NUM_CH-1:0] low_long;

  always_ff @(posedge clk_50M) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rst || lock_sync[i])
        low_cnt[i] <= '0;
      else if (low_cnt[i] != 2'd3)
        low_cnt[i] <= low_cnt[i] + 2'd1;
    end
  end

  always_comb begin
    low_long = '0;
    for (int unsigned i = 0; i < NUM_CH; i++)
      low_long[i] = !lock_sync[i] && (low_cnt[i] == 2'd3);
  end

  assign lost = |(en_q & low_long);
`else
  assign lost = |(en_q & ~lock_sync);
`endif

  assign hold_inc = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HW'(1);
  assign tmo_inc  = (tmo_cnt == TMO_MAX) ? tmo_cnt : tmo_cnt + TW'(1);
  assign pending  = en_q & ~rst_out_n;

  always_comb begin
    first = '0;
    for (int unsigned i = 0; i < NUM_CH; i++)
      if (pending[i] && (first == '0))
        first[i] = 1'b1;
  end

  always_comb begin
    state_d = state;
    hold_d  = hold_cnt;
    tmo_d   = tmo_cnt;
    retry_d = retry_cnt;
    en_d    = en_q;
    rel_d   = rst_out_n;
    case (state)
      ASSERT_PLL: begin
        en_d = ch_en;
        if (hold_cnt == HOLD_MAX) begin
          state_d = WAIT_LOCK;
          hold_d  = '0;
          tmo_d   = '0;
        end else begin
          hold_d = hold_inc;
        end
      end
      WAIT_LOCK: begin
        if (locked) begin
          state_d = RELEASE;
          hold_d  = '0;
        end else if (tmo_cnt == TMO_MAX) begin
          tmo_d = '0;
          if (retry_cnt < 4'(MAX_RETRY)) begin
            retry_d = retry_cnt + 4'd1;
            state_d = ASSERT_PLL;
            hold_d  = '0;
          end else begin
            state_d = FAULT;
          end
        end else begin
          tmo_d = tmo_inc;
        end
      end
      RELEASE: begin
        if (lost) begin
          state_d = ASSERT_PLL;
          hold_d  = '0;
        end else if (pending == '0) begin
          state_d = RUN;
        end else if (hold_cnt == HOLD_MAX) begin
          rel_d  = rst_out_n | first;
          hold_d = '0;
        end else begin
          hold_d = hold_inc;
        end
      end
      RUN: begin
        if (lost || restart) begin
          state_d = ASSERT_PLL;
          hold_d  = '0;
          retry_d = '0;
        end
      end
      FAULT: begin
        if (restart) begin
          state_d = ASSERT_PLL;
          hold_d  = '0;
          retry_d = '0;
        end
      end
      default: begin
        state_d = ASSERT_PLL;
        hold_d  = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_comb begin
    pll_d     = '0;
    rst_out_d = '0;
    case (state_d)
      ASSERT_PLL:   pll_d     = ch_en;
      FAULT:        pll_d     = en_d;
      RELEASE, RUN: rst_out_d = rel_d;
      default:      pll_d     = '0;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state     <= ASSERT_PLL;
      hold_cnt  <= '0;
      tmo_cnt   <= '0;
      en_q      <= '1;
      pll_rst   <= '1;
      rst_out_n <= '0;
      all_ready <= 1'b0;
      fault     <= 1'b0;
      retry_cnt <= '0;
    end else begin
      state     <= state_d;
      hold_cnt  <= hold_d;
      tmo_cnt   <= tmo_d;
      en_q      <= en_d;
      pll_rst   <= pll_d;
      rst_out_n <= rst_out_d;
      all_ready <= (state_d == RUN);
      fault     <= (state_d == FAULT);
      retry_cnt <= retry_d;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default instance plus a short-timeout instance for retry/fault.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] lock_in, ch_en, lock_t;
  logic       restart, restart_t;
  logic [3:0] pll_rst, rst_out_n, retry_cnt;
  logic       all_ready, fault;
  logic [3:0] pll_t, rstn_t, retry_t;
  logic       ready_t, fault_t;

  int tests = 0;
  int fails = 0;

  always #10 clk = ~clk;

  reset_sequencer #(.NUM_CH(4), .HOLD_CYCLES(16), .TIMEOUT_CYCLES(4096), .MAX_RETRY(3)) dut (
    .clk_50M(clk), .rst(rst), .lock_in(lock_in), .ch_en(ch_en), .restart(restart),
    .pll_rst(pll_rst), .rst_out_n(rst_out_n), .all_ready(all_ready), .fault(fault),
    .retry_cnt(retry_cnt)
  );

  reset_sequencer #(.NUM_CH(4), .HOLD_CYCLES(16), .TIMEOUT_CYCLES(64), .MAX_RETRY(2)) dut_t (
    .clk_50M(clk), .rst(rst), .lock_in(lock_t), .ch_en(ch_en), .restart(restart_t),
    .pll_rst(pll_t), .rst_out_n(rstn_t), .all_ready(ready_t), .fault(fault_t),
    .retry_cnt(retry_t)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mask == 0 waits for all_ready, otherwise for all mask bits of rst_out_n
  task automatic wait_out(input string tag, input logic [3:0] mask, input int bound);
    int n = 0;
    while (!((mask == 4'd0) ? all_ready : ((rst_out_n & mask) == mask)) && n < bound) begin
      step(1);
      n++;
    end
    check(tag, (mask == 4'd0) ? all_ready : ((rst_out_n & mask) == mask), 1);
  endtask

  initial begin
    rst = 1'b1; lock_in = 4'h0; lock_t = 4'h0; ch_en = 4'hF; restart = 1'b0; restart_t = 1'b0;
    step(3);
    check("rst_pll", pll_rst, 4'hF);
    check("rst_rstn", rst_out_n, 4'h0);
    check("rst_ready", all_ready, 0);
    check("rst_fault", fault, 0);
    check("rst_retry", retry_cnt, 0);
    check("rst_pll_t", pll_t, 4'hF);
    rst = 1'b0;
    step(15);
    check("hold_pll", pll_rst, 4'hF);
    step(1);
    check("hold_fall", pll_rst, 4'h0);
    check("hold_fall_t", pll_t, 4'h0);

    // short-timeout instance: 3 pll_rst pulses, retry 1 then 2, then fault
    step(63);
    check("tmo_pre_retry", retry_t, 0);
    check("tmo_pre_pll", pll_t, 4'h0);
    step(1);
    check("tmo1_retry", retry_t, 1);
    check("tmo1_pll", pll_t, 4'hF);
    step(80);
    check("tmo2_retry", retry_t, 2);
    check("tmo2_pll", pll_t, 4'hF);
    step(79);
    check("tmo3_pre_fault", fault_t, 0);
    check("tmo3_pre_pll", pll_t, 4'h0);
    step(1);
    check("tmo3_fault", fault_t, 1);
    check("tmo3_pll", pll_t, 4'hF);
    check("tmo3_retry", retry_t, 2);
    step(10);
    check("fault_sticky", fault_t, 1);
    restart_t = 1'b1;
    step(1);
    restart_t = 1'b0;
    check("restart_fault", fault_t, 0);
    check("restart_retry", retry_t, 0);
    check("restart_pll", pll_t, 4'hF);

    // fresh sequence: locks rise 100 cycles after pll_rst falls
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(16);
    check("seq_fall", pll_rst, 4'h0);
    step(99);
    lock_in = 4'hF;
    step(18);
    check("seq_pre_rel0", rst_out_n, 4'h0);
    step(1);
    check("seq_rel0", rst_out_n, 4'h1);
    step(15);
    check("seq_pre_rel1", rst_out_n, 4'h1);
    step(1);
    check("seq_rel1", rst_out_n, 4'h3);
    step(16);
    check("seq_rel2", rst_out_n, 4'h7);
    step(16);
    check("seq_rel3", rst_out_n, 4'hF);
    check("seq_ready_pre", all_ready, 0);
    step(1);
    check("seq_ready", all_ready, 1);
    check("seq_retry", retry_cnt, 0);

    // one-cycle glitch on lock_in[2]
    lock_in[2] = 1'b0;
    step(1);
    lock_in[2] = 1'b1;
    step(3);
`ifdef RSTSEQ_LOCK_FILTER_EN
    check("glitch_rstn", rst_out_n, 4'hF);
    check("glitch_ready", all_ready, 1);
`else
    check("glitch_rstn", rst_out_n, 4'h0);
    check("glitch_ready", all_ready, 0);
    check("glitch_pll", pll_rst, 4'hF);
    wait_out("glitch_recover", 4'h0, 300);
`endif

    // five-cycle loss re-sequences in both builds
    lock_in[2] = 1'b0;
    step(5);
    lock_in[2] = 1'b1;
    step(3);
    check("loss5_rstn", rst_out_n, 4'h0);
    check("loss5_pll", pll_rst, 4'hF);
    wait_out("loss5_recover", 4'h0, 300);

    // partial enable 0101: only bits 0 and 2 release
    ch_en = 4'b0101;
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    check("en_pll", pll_rst, 4'b0101);
    check("en_rstn0", rst_out_n, 4'h0);
    lock_in[1] = 1'b0;
    wait_out("en_wait0", 4'b0001, 60);
    check("en_rel0", rst_out_n, 4'b0001);
    step(15);
    check("en_pre_rel2", rst_out_n, 4'b0001);
    step(1);
    check("en_rel2", rst_out_n, 4'b0101);
    check("en_ready_pre", all_ready, 0);
    step(1);
    check("en_ready", all_ready, 1);
    for (int i = 0; i < 6; i++) begin
      lock_in[1] = ~lock_in[1];
      step(1);
    end
    step(4);
    check("en_toggle_rstn", rst_out_n, 4'b0101);
    check("en_toggle_ready", all_ready, 1);

    // rst during RELEASE after bit 1 has released
    lock_in = 4'hF;
    ch_en = 4'hF;
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    wait_out("mid_wait1", 4'b0011, 80);
    rst = 1'b1;
    step(1);
    check("mid_rstn", rst_out_n, 4'h0);
    check("mid_pll", pll_rst, 4'hF);
    check("mid_retry", retry_cnt, 0);
    check("mid_ready", all_ready, 0);
    rst = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_CH, default 4: number of clock sources (DCM/PLL) sequenced, 1..8.
REQ-002 Parameter HOLD_CYCLES, default 16: pll_rst assert width and spacing between channel reset releases, in clk_50M cycles, 2..65535.
REQ-003 Parameter TIMEOUT_CYCLES, default 4096: maximum wait for lock after pll_rst deassert, 16..2^20.
REQ-004 Parameter MAX_RETRY, default 3: lock timeouts tolerated before FAULT, 0..15.
REQ-005 clk_50M  input  1  sole clock; all logic on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 lock_in  input  NUM_CH  LOCKED flags from the clock sources, asynchronous to clk_50M.
REQ-008 ch_en  input  NUM_CH  channel enable mask, sampled only in ASSERT_PLL; disabled channels are ignored for lock checks.
REQ-009 restart  input  1  single-cycle request to leave FAULT or force a full re-sequence from RUN.
REQ-010 pll_rst  output  NUM_CH  active-high reset to each clock source.
REQ-011 rst_out_n  output  NUM_CH  active-low domain reset per channel.
REQ-012 all_ready  output  1  high only in RUN.
REQ-013 fault  output  1  high only in FAULT.
REQ-014 retry_cnt  output  4  timeouts counted since last entry to ASSERT_PLL from RESET, RUN or FAULT.

Function
REQ-015 lock_in shall pass through a 2-flop synchroniser per bit; all lock decisions use the synchronised value (2-cycle latency).
REQ-016 States: ASSERT_PLL, WAIT_LOCK, RELEASE, RUN, FAULT.
REQ-017 ASSERT_PLL: pll_rst = ch_en, rst_out_n = 0, all_ready = 0; after HOLD_CYCLES cycles -> WAIT_LOCK.
REQ-018 WAIT_LOCK: pll_rst = 0. When every enabled channel shows lock -> RELEASE. Otherwise, after TIMEOUT_CYCLES cycles: if retry_cnt < MAX_RETRY, increment retry_cnt and go to ASSERT_PLL; else -> FAULT.
REQ-019 Lock check and timeout in the same cycle: lock wins.
REQ-020 RELEASE: release rst_out_n of enabled channels one per HOLD_CYCLES interval, in ascending index order; the first release occurs HOLD_CYCLES cycles after entry.
REQ-021 Disabled channels keep rst_out_n = 0 and consume no interval.
REQ-022 RELEASE -> RUN one cycle after the last enabled release; ch_en = 0 goes directly to RUN after one cycle.
REQ-023 In RUN or RELEASE, loss of lock on any enabled channel -> ASSERT_PLL, and all rst_out_n = 0 in the same cycle the state is entered.
REQ-024 restart in RUN -> ASSERT_PLL; restart in FAULT -> ASSERT_PLL with retry_cnt cleared; restart in other states is ignored.
REQ-025 FAULT: pll_rst = ch_en held, rst_out_n = 0, fault = 1; FAULT is sticky.
REQ-026 Lock loss and restart in the same cycle: a single transition to ASSERT_PLL.
REQ-027 All outputs are registered; no combinational path from inputs to outputs.
REQ-028 Counters are sized by clog2 of their parameter and saturate; they never wrap.

Reset
REQ-029 rst, sampled on clk_50M, shall force: state ASSERT_PLL, pll_rst = all ones, rst_out_n = 0, all_ready = 0, fault = 0, retry_cnt = 0, counters 0, synchroniser flops 0.
REQ-030 rst asserted mid-sequence shall take effect at the next edge regardless of state, and takes priority over all other inputs.

Configuration
REQ-031 Macro RSTSEQ_LOCK_FILTER_EN defined: in RUN and RELEASE, lock loss is recognised only after 4 consecutive synchronised-low cycles; shorter glitches are ignored.
REQ-032 Macro RSTSEQ_LOCK_FILTER_EN undefined: a single synchronised-low cycle is recognised as lock loss.
REQ-033 The macro has no effect on WAIT_LOCK.

Verification
REQ-034 NUM_CH=4, HOLD=16, ch_en=4'hF, locks rise 100 cycles after pll_rst falls -> rst_out_n bits 0..3 release 16 cycles apart; all_ready = 1 one cycle after bit 3.
REQ-035 TIMEOUT=64, MAX_RETRY=2, lock_in held 0 -> three pll_rst pulses, retry_cnt reaches 2, then fault = 1; restart -> retry_cnt = 0 and ASSERT_PLL.
REQ-036 In RUN, lock_in[2] low for 1 cycle: filter off -> all rst_out_n = 0 and re-sequence; filter on -> no change. Low for 5 cycles -> re-sequence in both builds.
REQ-037 ch_en = 4'b0101 -> only bits 0 and 2 release, 16 cycles apart; bits 1 and 3 stay 0; lock_in[1] toggling has no effect.
REQ-038 rst asserted during RELEASE after bit 1 has released -> next cycle all rst_out_n = 0, pll_rst = 4'hF, retry_cnt = 0.
